bus_ram: RTL and testbench

//   Word-wide RAM responder on the RISC5 system bus (stb/we/addr[23:2]/ack).

---
 rtl/bus_ram.sv | 129 ++++++++++++
 tb/tb_bus_ram.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram.sv
// Word-wide RAM responder for the RISC5 system bus with fixed wait states.
// Optional write protection is enabled by defining BUS_RAM_WPROT_EN.
module bus_ram #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack
`ifdef BUS_RAM_WPROT_EN
  ,
  input  logic        wprot,
  output logic        wp_viol
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [3:0]             cnt_r, cnt_s;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   we_r;
  logic [31:0]            data_r;
  logic                   latch_s;
  logic                   rd_s;
  logic                   wr_s;
  logic                   wr_en_s;
  logic [31:0]            mem_r [2**ADDR_BITS];
  logic                   unused_addr_s;

  assign unused_addr_s = ^addr[21:ADDR_BITS];

  // Next-state, counter and strobe decode for one bus transaction
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    latch_s = 1'b0;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    ack     = 1'b0;
    case (state_r)
      IDLE: begin
        if (stb) begin
          latch_s = 1'b1;
          cnt_s   = 4'(WAIT_STATES);
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!stb) begin
          state_s = IDLE;
        end else if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s = ACK;
          rd_s    = ~we_r;
        end
      end
      ACK: begin
        // A dropped strobe here withdraws the request: no ack, no write.
        ack     = stb;
        wr_s    = stb & we_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef BUS_RAM_WPROT_EN
  assign wr_en_s = wr_s & ~wprot;
`else
  assign wr_en_s = wr_s;
`endif

  // Control state, request latch and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      we_r     <= 1'b0;
      data_r   <= 32'd0;
      data_out <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (latch_s) begin
        addr_r <= addr[ADDR_BITS-1:0];
        we_r   <= we;
        data_r <= data_in;
      end
      if (rd_s) begin
        data_out <= mem_r[addr_r];
      end
    end
  end

  // RAM array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[addr_r] <= data_r;
    end
  end

`ifdef BUS_RAM_WPROT_EN
  // Sticky flag for a write blocked by protection
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_viol <= 1'b0;
    end else if (wr_s && wprot) begin
      wp_viol <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_ram.sv
// Self-checking bench for bus_ram: three instances (1, 0 and 15 wait states)
// against a cycle-timeline model, plus directed literal checks.
module tb_bus_ram;
  localparam int AB   = 12;
  localparam int NDUT = 3;
  localparam int WS [NDUT] = '{1, 0, 15};

  logic        clk = 1'b0;
  logic        rst;
  logic        stb  [NDUT];
  logic        we   [NDUT];
  logic [21:0] addr [NDUT];
  logic [31:0] din  [NDUT];
  logic [31:0] dout [NDUT];
  logic        ack  [NDUT];
`ifdef BUS_RAM_WPROT_EN
  logic        wprot [NDUT];
  logic        wpv   [NDUT];
`endif

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // timeline model state per instance
  logic [31:0]   mm    [NDUT][2**AB];
  bit            mv    [NDUT][2**AB];
  int            phase [NDUT];
  logic [AB-1:0] ma    [NDUT];
  bit            mwe   [NDUT];
  logic [31:0]   md    [NDUT];
  logic [31:0]   edout [NDUT];
  bit            edv   [NDUT];
  bit            ewp   [NDUT];

  always #5 clk = ~clk;

  bus_ram #(.ADDR_BITS(AB), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .stb(stb[0]), .we(we[0]), .addr(addr[0]),
    .data_in(din[0]), .data_out(dout[0]), .ack(ack[0])
`ifdef BUS_RAM_WPROT_EN
    , .wprot(wprot[0]), .wp_viol(wpv[0])
`endif
  );
  bus_ram #(.ADDR_BITS(AB), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .stb(stb[1]), .we(we[1]), .addr(addr[1]),
    .data_in(din[1]), .data_out(dout[1]), .ack(ack[1])
`ifdef BUS_RAM_WPROT_EN
    , .wprot(wprot[1]), .wp_viol(wpv[1])
`endif
  );
  bus_ram #(.ADDR_BITS(AB), .WAIT_STATES(15)) u2 (
    .clk(clk), .rst(rst), .stb(stb[2]), .we(we[2]), .addr(addr[2]),
    .data_in(din[2]), .data_out(dout[2]), .ack(ack[2])
`ifdef BUS_RAM_WPROT_EN
    , .wprot(wprot[2]), .wp_viol(wpv[2])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Per-cycle compare, then advance the model by one cycle
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!rst && started) begin
        chk($sformatf("ack cycle dut%0d", i), {31'd0, ack[i]},
            {31'd0, (phase[i] == 2 + WS[i]) && stb[i]});
        if (edv[i]) chk($sformatf("data_out cycle dut%0d", i), dout[i], edout[i]);
`ifdef BUS_RAM_WPROT_EN
        chk($sformatf("wp_viol cycle dut%0d", i), {31'd0, wpv[i]}, {31'd0, ewp[i]});
`endif
      end
      if (rst) begin
        phase[i] = 0;
        edout[i] = 32'd0;
        edv[i]   = 1'b1;
        ewp[i]   = 1'b0;
      end else if (phase[i] == 0) begin
        if (stb[i]) begin
          ma[i]    = addr[i][AB-1:0];
          mwe[i]   = we[i];
          md[i]    = din[i];
          phase[i] = 1;
        end
      end else if (phase[i] <= 1 + WS[i]) begin
        if (!stb[i]) begin
          phase[i] = 0;
        end else begin
          if (phase[i] == 1 + WS[i] && !mwe[i]) begin
            edout[i] = mm[i][ma[i]];
            edv[i]   = mv[i][ma[i]];
          end
          phase[i]++;
        end
      end else begin
        if (stb[i] && mwe[i]) begin
`ifdef BUS_RAM_WPROT_EN
          if (wprot[i]) ewp[i] = 1'b1;
          else begin
            mm[i][ma[i]] = md[i];
            mv[i][ma[i]] = 1'b1;
          end
`else
          mm[i][ma[i]] = md[i];
          mv[i][ma[i]] = 1'b1;
`endif
        end
        phase[i] = 0;
      end
    end
    if (rst) started = 1'b1;
  end

  task automatic go(input int i, input logic w, input logic [21:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    stb[i] = 1'b1; we[i] = w; addr[i] = a; din[i] = d;
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    stb[i] = 1'b0;
  endtask

  // Counts cycles from the strobe's first cycle until ack, bounded
  task automatic wait_ack(input int i, input int lat, input string nm);
    int  k;
    bit  found;
    k = 0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack[i] === 1'b1) begin
        found = 1'b1;
        break;
      end
      k++;
    end
    if (found) chk(nm, k, lat);
    else begin
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=ack", nm);
    end
  endtask

  initial begin
    int na;
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      stb[i] = 1'b0; we[i] = 1'b0; addr[i] = 22'd0; din[i] = 32'd0;
`ifdef BUS_RAM_WPROT_EN
      wprot[i] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("reset ack", {31'd0, ack[i]}, 32'd0);
      chk("reset data_out", dout[i], 32'd0);
    end

    // write then read
    go(0, 1'b1, 22'h10, 32'hDEADBEEF); wait_ack(0, 3, "t1 write latency"); idle(0);
    go(0, 1'b0, 22'h10, 32'd0);        wait_ack(0, 3, "t1 read latency");
    chk("t1 read data", dout[0], 32'hDEADBEEF); idle(0);

    // back-to-back read then write with stb held high
    go(0, 1'b1, 22'h20, 32'h11223344); wait_ack(0, 3, "t2 preload latency"); idle(0);
    go(0, 1'b0, 22'h20, 32'd0);        wait_ack(0, 3, "t2 read latency");
    chk("t2 read data", dout[0], 32'h11223344);
    go(0, 1'b1, 22'h20, 32'h11AA3344); wait_ack(0, 3, "t2 write latency");
    chk("t2 data_out held", dout[0], 32'h11223344); idle(0);
    go(0, 1'b0, 22'h20, 32'd0);        wait_ack(0, 3, "t2 reread latency");
    chk("t2 reread data", dout[0], 32'h11AA3344); idle(0);

    // abort in BUSY
    go(0, 1'b1, 22'h30, 32'h00000077); wait_ack(0, 3, "t3 preload latency"); idle(0);
    go(0, 1'b1, 22'h30, 32'h00000055); idle(0);
    na = 0;
    repeat (6) begin @(negedge clk); if (ack[0] === 1'b1) na++; end
    chk("t3 no ack after abort", na, 0);
    go(0, 1'b0, 22'h30, 32'd0);        wait_ack(0, 3, "t3 read latency");
    chk("t3 word unchanged", dout[0], 32'h00000077); idle(0);

    // reset during BUSY of a write
    go(0, 1'b1, 22'h40, 32'h12345678); wait_ack(0, 3, "t4 preload latency"); idle(0);
    go(0, 1'b1, 22'h40, 32'hA5A5A5A5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    chk("t4 ack after reset", {31'd0, ack[0]}, 32'd0);
    chk("t4 data_out after reset", dout[0], 32'd0);
    go(0, 1'b0, 22'h40, 32'd0);        wait_ack(0, 3, "t4 read latency");
    chk("t4 word unchanged", dout[0], 32'h12345678); idle(0);

    // wait-state extremes
    go(1, 1'b1, 22'h5, 32'h13579BDF);  wait_ack(1, 2, "t5 ws0 write latency"); idle(1);
    go(1, 1'b0, 22'h5, 32'd0);         wait_ack(1, 2, "t5 ws0 read latency");
    chk("t5 ws0 read data", dout[1], 32'h13579BDF); idle(1);
    go(2, 1'b1, 22'h6, 32'h2468ACE0);  wait_ack(2, 17, "t5 ws15 write latency"); idle(2);
    go(2, 1'b0, 22'h6, 32'd0);         wait_ack(2, 17, "t5 ws15 read latency");
    chk("t5 ws15 read data", dout[2], 32'h2468ACE0); idle(2);

`ifdef BUS_RAM_WPROT_EN
    // protected write
    go(0, 1'b1, 22'h50, 32'h0BADF00D); wait_ack(0, 3, "t6 preload latency"); idle(0);
    @(negedge clk);
    chk("t6 wp_viol clear", {31'd0, wpv[0]}, 32'd0);
    wprot[0] = 1'b1;
    go(0, 1'b1, 22'h50, 32'hCAFEF00D); wait_ack(0, 3, "t6 protected write latency"); idle(0);
    wprot[0] = 1'b0;
    @(negedge clk);
    chk("t6 wp_viol set", {31'd0, wpv[0]}, 32'd1);
    go(0, 1'b0, 22'h50, 32'd0);        wait_ack(0, 3, "t6 read latency");
    chk("t6 word kept", dout[0], 32'h0BADF00D);
    chk("t6 wp_viol sticky", {31'd0, wpv[0]}, 32'd1); idle(0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6 wp_viol after reset", {31'd0, wpv[0]}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
